// File: rtl/fifo_pkg.sv
// Shared sizing constants and types for the RAM-backed first-word-fall-through FIFO.
package fifo_pkg;

    localparam int occ_width          = 2;
    localparam int default_addr_width = 8;

    typedef logic [occ_width-1:0]            occ_t;
    typedef logic [default_addr_width+1:0]   level_t;

endpackage

// File: rtl/dpram.sv
// True dual-port RAM with registered read data on both ports; q outputs float to
// disable_value while the port is deselected.
module dpram #(
    parameter int    addr_width    = 8,
    parameter int    data_width    = 16,
    parameter bit    disable_value = 1'b0,
    parameter string mem_init_file = " "
) (
    input  logic                  clock,
    input  logic [addr_width-1:0] address_a,
    input  logic [addr_width-1:0] address_b,
    input  logic [data_width-1:0] data_a,
    input  logic [data_width-1:0] data_b,
    input  logic                  wren_a,
    input  logic                  wren_b,
    input  logic                  enable_a,
    input  logic                  enable_b,
    input  logic                  cs_a,
    input  logic                  cs_b,
    output logic [data_width-1:0] q_a,
    output logic [data_width-1:0] q_b
);

    logic [data_width-1:0] mem [0:(1<<addr_width)-1];
    logic [data_width-1:0] q_a_reg;
    logic [data_width-1:0] q_b_reg;

    // A named init file is loaded by the vendor macro flow; this model starts undefined.
    if (mem_init_file != " ") begin : g_preload
    end

    // NOTE: the storage array has no reset; RAM macros cannot be cleared in one cycle,
    // so the controller guarantees no location is read before it is written.
    always_ff @(posedge clock) begin
        if (enable_a && cs_a) begin
            if (wren_a) mem[address_a] <= data_a;
            q_a_reg <= mem[address_a];
        end
        if (enable_b && cs_b) begin
            if (wren_b) mem[address_b] <= data_b;
            q_b_reg <= mem[address_b];
        end
    end

    assign q_a = cs_a ? q_a_reg : {data_width{disable_value}};
    assign q_b = cs_b ? q_b_reg : {data_width{disable_value}};

endmodule

// File: rtl/dpram_fifo.sv
// FWFT FIFO on a dual-port RAM: port A writes, port B prefetches into a two-entry
// output stage (head + skid) so one word can be popped every cycle.
module dpram_fifo
    import fifo_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [data_width-1:0] rd_data,
    output logic                  rd_valid,
    output logic [addr_width+1:0] level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int depth = 1 << addr_width;

    typedef logic [addr_width-1:0] ptr_t;
    typedef logic [addr_width:0]   cnt_t;

    ptr_t                  wptr;
    ptr_t                  rptr;
    cnt_t                  ram_cnt;
    logic                  inflight;
    occ_t                  occ;
    logic [data_width-1:0] head;
    logic [data_width-1:0] skid;
    logic [data_width-1:0] q_b;
    logic [data_width-1:0] unused_q_a;

    logic                  push;
    logic                  pop;
    logic                  fetch;
    occ_t                  occ_after_pop;
    logic [2:0]            stage_after_pop;

    assign full     = (ram_cnt == cnt_t'(depth));
    assign rd_valid = (occ != '0);
    assign rd_data  = head;

    // clear wins over same-cycle traffic, so it also keeps the RAM ports idle.
    assign push  = wr_en & ~full & ~clear;
    assign pop   = rd_en & rd_valid & ~clear;

    assign occ_after_pop   = occ - occ_t'(pop);
    assign stage_after_pop = {1'b0, occ_after_pop} + {2'b0, inflight};
    assign fetch           = (ram_cnt != '0) & (stage_after_pop < 3'd2) & ~clear;

    assign level = {1'b0, ram_cnt}
                 + {{(addr_width+1){1'b0}}, inflight}
                 + {{addr_width{1'b0}}, occ};

    // NOTE: every state register here is assigned with <= so all updates in this
    // block see the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            ram_cnt   <= '0;
            inflight  <= 1'b0;
            occ       <= '0;
            head      <= '0;
            skid      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            occ      <= '0;
            head     <= '0;
            skid     <= '0;
        end else begin
            if (wr_en && full)      overflow  <= 1'b1;
            if (rd_en && !rd_valid) underflow <= 1'b1;

            if (push)  wptr <= wptr + ptr_t'(1);
            if (fetch) rptr <= rptr + ptr_t'(1);

            ram_cnt  <= ram_cnt + cnt_t'(push) - cnt_t'(fetch);
            inflight <= fetch;
            occ      <= stage_after_pop[1:0];

            if (pop && occ == occ_t'(2)) head <= skid;

            // Landing goes to the first slot left free after this cycle's pop.
            if (inflight) begin
                if (occ_after_pop == '0) head <= q_b;
                else                     skid <= q_b;
            end
        end
    end

    dpram #(
        .addr_width    (addr_width),
        .data_width    (data_width),
        .disable_value (1'b1),
        .mem_init_file (" ")
    ) u_dpram (
        .clock     (clock),
        .address_a (wptr),
        .address_b (rptr),
        .data_a    (wr_data),
        .data_b    ('0),
        .wren_a    (push),
        .wren_b    (1'b0),
        .enable_a  (push),
        .enable_b  (fetch),
        .cs_a      (1'b1),
        .cs_b      (1'b1),
        .q_a       (unused_q_a),
        .q_b       (q_b)
    );

endmodule

// File: tb/tb_dpram_fifo.sv
// Directed bench for dpram_fifo with a 16-deep RAM (capacity 18), hand-computed expectations.
module tb_dpram_fifo;

    localparam int aw = 4;
    localparam int dw = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [dw-1:0] wr_data = '0;
    logic          full;
    logic          rd_en = 1'b0;
    logic [dw-1:0] rd_data;
    logic          rd_valid;
    logic [aw+1:0] level;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    dpram_fifo #(
        .addr_width (aw),
        .data_width (dw)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the head word, compare it, then pop it.
    task automatic pop_expect(input string tag, input logic [dw-1:0] exp);
        int n = 0;
        rd_en = 1'b0;
        while (!rd_valid && n < 8) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check(tag, {16'b0, rd_data}, {16'b0, exp});
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int popped;
        int bubbles;
        bit started;

        // Reset state
        #12;
        reset = 1'b0;
        check("rst_full",      {31'b0, full},      32'd0);
        check("rst_rd_valid",  {31'b0, rd_valid},  32'd0);
        check("rst_rd_data",   {16'b0, rd_data},   32'd0);
        check("rst_level",     {26'b0, level},     32'd0);
        check("rst_overflow",  {31'b0, overflow},  32'd0);
        check("rst_underflow", {31'b0, underflow}, 32'd0);
        step();

        // Single word: push in cycle 0, valid in cycle 3
        wr_en = 1'b1; wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        check("single_c1_valid", {31'b0, rd_valid}, 32'd0);
        check("single_c1_level", {26'b0, level},    32'd1);
        step();
        check("single_c2_valid", {31'b0, rd_valid}, 32'd0);
        check("single_c2_level", {26'b0, level},    32'd1);
        step();
        check("single_c3_valid", {31'b0, rd_valid}, 32'd1);
        check("single_c3_data",  {16'b0, rd_data},  32'h1234);
        check("single_c3_level", {26'b0, level},    32'd1);
        pop_expect("single_pop", 16'h1234);
        check("single_empty", {26'b0, level}, 32'd0);

        // Fill to capacity 18, then one refused push
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = dw'(i);
            step();
            if (i == 16) check("fill_not_full", {31'b0, full}, 32'd0);
            if (i == 17) check("fill_full",     {31'b0, full}, 32'd1);
        end
        check("fill_no_ovf", {31'b0, overflow}, 32'd0);
        wr_data = 16'hDEAD;
        step();
        wr_en = 1'b0;
        check("fill_overflow", {31'b0, overflow}, 32'd1);
        check("fill_level",    {26'b0, level},    32'd18);

        for (int i = 0; i < 18; i++) pop_expect("drain", dw'(i));
        step(); step(); step();
        check("drain_valid", {31'b0, rd_valid}, 32'd0);
        check("drain_level", {26'b0, level},    32'd0);

        // Streaming: push 40 while popping every valid cycle
        pushed = 0; popped = 0; bubbles = 0; started = 0;
        for (int cyc = 0; cyc < 200 && popped < 40; cyc++) begin
            wr_en   = (pushed < 40);
            wr_data = 16'h0100 + dw'(pushed);
            rd_en   = rd_valid;
            if (rd_valid) begin
                check("stream_data", {16'b0, rd_data}, 32'h0100 + 32'(popped));
                started = 1;
            end else if (started) begin
                bubbles++;
            end
            step();
            if (wr_en) pushed++;
            if (rd_en) popped++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("stream_count",   32'(popped),  32'd40);
        check("stream_bubbles", 32'(bubbles), 32'd0);
        check("stream_level",   {26'b0, level}, 32'd0);

        // Underflow is sticky through clear
        check("uf_before", {31'b0, underflow}, 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("uf_set",   {31'b0, underflow}, 32'd1);
        check("uf_level", {26'b0, level},     32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("uf_kept_by_clear",  {31'b0, underflow}, 32'd1);
        check("ovf_kept_by_clear", {31'b0, overflow},  32'd1);

        // Clear while a fetch is in flight
        wr_en = 1'b1; wr_data = 16'h5555;
        step();
        wr_en = 1'b0;
        step();
        check("clr_pre_level", {26'b0, level}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_level",   {26'b0, level},    32'd0);
        check("clr_valid",   {31'b0, rd_valid}, 32'd0);
        check("clr_rd_data", {16'b0, rd_data},  32'd0);
        wr_en = 1'b1; wr_data = 16'hBEEF;
        step();
        wr_en = 1'b0;
        pop_expect("clr_beef", 16'hBEEF);
        step(); step(); step(); step();
        check("clr_no_stale", {31'b0, rd_valid}, 32'd0);
        check("clr_end_level", {26'b0, level},   32'd0);

        // Asynchronous reset mid-stream at level 9
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 16'h0A00 + dw'(i);
            step();
        end
        wr_en = 1'b0;
        check("mid_level", {26'b0, level},    32'd9);
        check("mid_valid", {31'b0, rd_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_full",      {31'b0, full},      32'd0);
        check("arst_rd_valid",  {31'b0, rd_valid},  32'd0);
        check("arst_rd_data",   {16'b0, rd_data},   32'd0);
        check("arst_level",     {26'b0, level},     32'd0);
        check("arst_overflow",  {31'b0, overflow},  32'd0);
        check("arst_underflow", {31'b0, underflow}, 32'd0);
        #2;
        reset = 1'b0;
        step();
        check("post_rst_level", {26'b0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
